// File: rtl/morph_pipe_ctrl.sv
// morph_pipe_ctrl: sequences ROM reads into a 3-line buffer feeding a 3x3
// morphology window. Each frame clears the line buffer, prefills PRE_LINES
// rows, then reads one row per raster line just ahead of the display window.
module morph_pipe_ctrl #(
  parameter int PIC_WIDTH   = 250,
  parameter int PIC_HEIGHT  = 250,
  parameter int PIC_X_START = 310,
  parameter int PIC_Y_START = 10,
  parameter int PRE_LINES   = 2,
  parameter int LEAD        = 12,
  parameter int ADDR_W      = 16
) (
  input  logic              lcd_pclk,
  input  logic              rst,
  input  logic              frame_start,
  input  logic [10:0]       pixel_xpos,
  input  logic [10:0]       pixel_ypos,
  input  logic              fifo_rst_busy,
  output logic              fifo_rst,
  output logic              rom_rd_en,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              lb_wr_en,
  output logic              lb_rd_en,
  output logic              win_valid,
  output logic              busy,
  output logic              frame_done,
  output logic              err
);

  localparam int unsigned PRE_LEN = PRE_LINES * PIC_WIDTH;
  localparam int unsigned TOTAL   = PIC_WIDTH * PIC_HEIGHT;
  localparam int unsigned CNT_MAX = (PRE_LEN > PIC_WIDTH) ? PRE_LEN : PIC_WIDTH;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [10:0]       TRIG_X    = 11'(PIC_X_START - LEAD);
  localparam logic [10:0]       Y_LO      = 11'(PIC_Y_START);
  localparam logic [10:0]       Y_HI      = 11'(PIC_Y_START + PIC_HEIGHT - PRE_LINES);
  localparam logic [CNT_W-1:0]  PRE_LAST  = CNT_W'(PRE_LEN - 1);
  localparam logic [CNT_W-1:0]  RUN_LAST  = CNT_W'(PIC_WIDTH - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [ADDR_W:0]   LAST_ADDR = (ADDR_W+1)'(TOTAL - 1);
  localparam logic [ADDR_W:0]   ADDR_ONE  = (ADDR_W+1)'(1);

  // Reject geometries the address and counter widths cannot hold.
  if (longint'(PIC_WIDTH) * longint'(PIC_HEIGHT) > (longint'(1) << ADDR_W)) begin : g_bad_addr_w
    $error("PIC_WIDTH*PIC_HEIGHT exceeds 2**ADDR_W");
  end
  if (PRE_LINES < 1 || PRE_LINES >= PIC_HEIGHT) begin : g_bad_pre_lines
    $error("PRE_LINES must be in [1, PIC_HEIGHT)");
  end

  typedef enum logic [2:0] {IDLE, CLEAR, PREFILL, WAIT_ROW, RUN, DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W:0]   addr_q, addr_d;         // one spare bit so TOTAL is representable
  logic [CNT_W-1:0]  cnt_q, cnt_d;           // reads within prefill or within a row
  logic [1:0]        clr_q, clr_d;           // cycles spent in CLEAR, saturates at 2
  logic [10:0]       last_row_q, last_row_d; // row of the most recent trigger
  logic              fifo_rst_q, fifo_rst_d;
  logic              err_q, err_d;
  logic              lb_wr_q, lb_wr_d;
  logic              lb_rd_q, lb_rd_d;
  logic              win_q, win_d;
  logic              rd_en, run_rd, done_c, in_win;

  // Next-state, counters, delay stages and strobes; frame_start overrides all.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    clr_d      = clr_q;
    last_row_d = last_row_q;
    err_d      = err_q;
    fifo_rst_d = 1'b0;
    rd_en      = 1'b0;
    run_rd     = 1'b0;
    done_c     = 1'b0;
    in_win     = (pixel_ypos >= Y_LO) && (pixel_ypos < Y_HI);

    case (state_q)
      IDLE: ;
      CLEAR: begin
        if (clr_q != 2'd2) clr_d = clr_q + 2'd1;
        if (clr_q == 2'd2 && !fifo_rst_busy) begin
          state_d = PREFILL;
          cnt_d   = '0;
        end
      end
      PREFILL: begin
        rd_en  = 1'b1;
        addr_d = addr_q + ADDR_ONE;
        if (cnt_q == PRE_LAST) begin
          cnt_d   = '0;
          state_d = WAIT_ROW;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      WAIT_ROW: begin
        if (pixel_xpos == TRIG_X && in_win && pixel_ypos != last_row_q) begin
          state_d    = RUN;
          last_row_d = pixel_ypos;
          cnt_d      = '0;
        end else if (pixel_ypos >= Y_HI) begin
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      RUN: begin
        rd_en  = 1'b1;
        run_rd = 1'b1;
        addr_d = addr_q + ADDR_ONE;
        if (cnt_q == RUN_LAST) begin
          cnt_d   = '0;
          state_d = (addr_q == LAST_ADDR) ? DONE : WAIT_ROW;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      DONE: begin
        if (!lb_wr_q && !lb_rd_q && !win_q) begin
          done_c  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    lb_wr_d = rd_en;
    lb_rd_d = run_rd;
    win_d   = lb_rd_q;

    // A start outside IDLE is an abort: flush the pipeline so nothing of the
    // old frame reaches the line buffer or window, and suppress frame_done.
    if (frame_start) begin
      state_d    = CLEAR;
      fifo_rst_d = 1'b1;
      addr_d     = '0;
      cnt_d      = '0;
      clr_d      = '0;
      last_row_d = '1;
      lb_wr_d    = 1'b0;
      lb_rd_d    = 1'b0;
      win_d      = 1'b0;
      done_c     = 1'b0;
      if (state_q != IDLE) err_d = 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge lcd_pclk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Datapath registers: address, counters, delay stages, sticky error.
  always_ff @(posedge lcd_pclk or posedge rst) begin
    if (rst) begin
      addr_q     <= '0;
      cnt_q      <= '0;
      clr_q      <= '0;
      last_row_q <= '0;
      fifo_rst_q <= 1'b0;
      err_q      <= 1'b0;
      lb_wr_q    <= 1'b0;
      lb_rd_q    <= 1'b0;
      win_q      <= 1'b0;
    end else begin
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      clr_q      <= clr_d;
      last_row_q <= last_row_d;
      fifo_rst_q <= fifo_rst_d;
      err_q      <= err_d;
      lb_wr_q    <= lb_wr_d;
      lb_rd_q    <= lb_rd_d;
      win_q      <= win_d;
    end
  end

  assign fifo_rst   = fifo_rst_q;
  assign rom_rd_en  = rd_en;
  // Saturate rather than wrap when the frame fills the full address space.
  assign rom_addr   = addr_q[ADDR_W] ? '1 : addr_q[ADDR_W-1:0];
  assign lb_wr_en   = lb_wr_q;
  assign lb_rd_en   = lb_rd_q;
  assign win_valid  = win_q;
  assign busy       = (state_q != IDLE);
  assign frame_done = done_c;
  assign err        = err_q;

endmodule

// File: tb/tb_morph_pipe_ctrl.sv
// Directed bench for morph_pipe_ctrl on an 8x4 picture, window at (20,2).
module tb_morph_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst, fs, fbusy;
  logic [10:0] xpos, ypos;
  logic        fifo_rst, rom_rd_en, lb_wr_en, lb_rd_en, win_valid, busy, frame_done, err;
  logic [15:0] rom_addr;

  always #5 clk = ~clk;

  morph_pipe_ctrl #(
    .PIC_WIDTH(8), .PIC_HEIGHT(4), .PIC_X_START(20), .PIC_Y_START(2),
    .PRE_LINES(2), .LEAD(3), .ADDR_W(16)
  ) dut (
    .lcd_pclk(clk), .rst(rst), .frame_start(fs), .pixel_xpos(xpos), .pixel_ypos(ypos),
    .fifo_rst_busy(fbusy), .fifo_rst(fifo_rst), .rom_rd_en(rom_rd_en), .rom_addr(rom_addr),
    .lb_wr_en(lb_wr_en), .lb_rd_en(lb_rd_en), .win_valid(win_valid), .busy(busy),
    .frame_done(frame_done), .err(err)
  );

  typedef struct {
    logic        fs;
    logic        fb;
    logic [23:0] exp;  // {fifo_rst, rd, addr[15:0], lb_wr, lb_rd, win, busy, done, err}
  } vec_t;

  vec_t vecs[7];
  int   total = 0, bad = 0;
  int   n_rd, n_wr, n_lbrd, n_win, n_done, n_frst;
  int   rd_log[$];

  function automatic logic [23:0] outs();
    return {fifo_rst, rom_rd_en, rom_addr, lb_wr_en, lb_rd_en, win_valid, busy, frame_done, err};
  endfunction

  function automatic logic [23:0] mk(input logic frst, input logic rd, input int addr,
                                     input logic wr, input logic lrd, input logic bsy);
    return {frst, rd, 16'(addr), wr, lrd, 1'b0, bsy, 1'b0, 1'b0};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_stats();
    n_rd = 0; n_wr = 0; n_lbrd = 0; n_win = 0; n_done = 0; n_frst = 0;
    rd_log.delete();
  endtask

  // Advance one clock and log the outputs seen after it.
  task automatic step();
    @(posedge clk);
    #2;
    if (rom_rd_en) begin n_rd++; rd_log.push_back(int'(rom_addr)); end
    n_wr   += int'(lb_wr_en);
    n_lbrd += int'(lb_rd_en);
    n_win  += int'(win_valid);
    n_done += int'(frame_done);
    n_frst += int'(fifo_rst);
  endtask

  task automatic wait_prefill();
    int k = 0;
    while (!(n_rd >= 16 && !rom_rd_en) && k < 200) begin step(); k++; end
    check("prefill_in_time", 32'(k < 200), 32'd1);
  endtask

  task automatic do_row(input int row, input bit timing, input int first);
    int k = 0;
    xpos = 11'd17; ypos = 11'(row);
    step();
    xpos = 11'd0;
    if (timing) begin
      check("trig_c1", {rom_rd_en, lb_rd_en, win_valid}, 3'b100);
      check("trig_addr", 32'(rom_addr), 32'(first));
      step();
      check("trig_c2", {rom_rd_en, lb_rd_en, win_valid}, 3'b110);
      step();
      check("trig_c3", {rom_rd_en, lb_rd_en, win_valid}, 3'b111);
    end
    while (rom_rd_en && k < 50) begin step(); k++; end
    check("row_in_time", 32'(k < 50), 32'd1);
  endtask

  task automatic finish_frame();
    int r = 0;
    int k = 0;
    wait_prefill();
    do_row(2, 1'b1, 16);
    xpos = 11'd17; ypos = 11'd2;
    for (int i = 0; i < 3; i++) begin step(); r += int'(rom_rd_en); end
    check("no_retrigger_same_row", 32'(r), 32'd0);
    xpos = 11'd0;
    do_row(3, 1'b0, 24);
    while (n_done == 0 && k < 30) begin step(); k++; end
    check("done_in_time", 32'(k < 30), 32'd1);
    step();
    check("busy_after_done", {busy, frame_done}, 2'b00);
  endtask

  task automatic check_stats(input int exp_frst);
    int mism = 0;
    check("n_fifo_rst", 32'(n_frst), 32'(exp_frst));
    check("n_rom_rd", 32'(n_rd), 32'd32);
    foreach (rd_log[i]) if (rd_log[i] != i) mism++;
    check("rd_addr_seq", 32'(mism), 32'd0);
    check("n_lb_wr", 32'(n_wr), 32'd32);
    check("n_lb_rd", 32'(n_lbrd), 32'd16);
    check("n_win_valid", 32'(n_win), 32'd16);
    check("n_frame_done", 32'(n_done), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    int k;
    vecs[0] = '{fs: 1'b1, fb: 1'b0, exp: mk(1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b1)};
    vecs[1] = '{fs: 1'b0, fb: 1'b0, exp: mk(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1)};
    vecs[2] = '{fs: 1'b0, fb: 1'b0, exp: mk(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1)};
    vecs[3] = '{fs: 1'b0, fb: 1'b0, exp: mk(1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b1)};
    vecs[4] = '{fs: 1'b0, fb: 1'b0, exp: mk(1'b0, 1'b1, 1, 1'b1, 1'b0, 1'b1)};
    vecs[5] = '{fs: 1'b0, fb: 1'b0, exp: mk(1'b0, 1'b1, 2, 1'b1, 1'b0, 1'b1)};
    vecs[6] = '{fs: 1'b0, fb: 1'b1, exp: mk(1'b0, 1'b1, 3, 1'b1, 1'b0, 1'b1)};

    rst = 1'b1; fs = 1'b0; fbusy = 1'b0; xpos = 11'd0; ypos = 11'd2;
    clear_stats();
    repeat (3) step();
    check("reset_outs", 32'(outs()), 32'd0);
    rst = 1'b0;

    // Nominal frame: table covers start, clear and early prefill.
    clear_stats();
    foreach (vecs[i]) begin
      fs = vecs[i].fs; fbusy = vecs[i].fb;
      step();
      check($sformatf("vec%0d", i), 32'(outs()), 32'(vecs[i].exp));
    end
    fs = 1'b0; fbusy = 1'b0;
    finish_frame();
    check_stats(1);

    // Line-buffer reset held busy for 10 cycles, then abort mid-prefill.
    clear_stats();
    fs = 1'b1; fbusy = 1'b1;
    step();
    fs = 1'b0;
    r = int'(rom_rd_en);
    for (int i = 0; i < 9; i++) begin step(); r += int'(rom_rd_en); end
    check("busy_hold_no_rd", 32'(r), 32'd0);
    fbusy = 1'b0;
    step();
    check("rd_after_busy", {rom_rd_en, rom_addr}, {1'b1, 16'd0});
    k = 0;
    while (!(rom_rd_en && rom_addr == 16'd9) && k < 40) begin step(); k++; end
    check("reach_addr9", 32'(k < 40), 32'd1);
    fs = 1'b1;
    step();
    fs = 1'b0;
    check("abort_outs", 32'(outs()),
          32'({1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1}));
    clear_stats();
    step();
    check("abort_fifo_rst_one_cycle", 32'(fifo_rst), 32'd0);
    finish_frame();
    check_stats(0);
    check("err_sticky", 32'(err), 32'd1);

    // Raster runs past the last trigger row before the frame completes.
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("err_cleared_by_rst", 32'(err), 32'd0);
    clear_stats();
    fs = 1'b1;
    step();
    fs = 1'b0;
    wait_prefill();
    xpos = 11'd17; ypos = 11'd1;
    r = 0;
    for (int i = 0; i < 2; i++) begin step(); r += int'(rom_rd_en) + int'(err); end
    check("above_window_no_trig", 32'(r), 32'd0);
    xpos = 11'd0; ypos = 11'd4;
    step();
    check("ylimit_err_done", {err, frame_done, busy}, 3'b111);
    step();
    check("ylimit_idle", {busy, frame_done, err}, 3'b001);

    // Asynchronous reset in the middle of a RUN burst.
    ypos = 11'd2;
    clear_stats();
    fs = 1'b1;
    step();
    fs = 1'b0;
    wait_prefill();
    xpos = 11'd17; ypos = 11'd2;
    step();
    xpos = 11'd0;
    step();
    step();
    check("in_run_before_rst", {rom_rd_en, win_valid}, 2'b11);
    #1 rst = 1'b1;
    #1 check("rst_async_outs", 32'(outs()), 32'd0);
    step();
    rst = 1'b0;
    clear_stats();
    fs = 1'b1;
    step();
    fs = 1'b0;
    finish_frame();
    check_stats(1);
    check("err_after_rst_frame", 32'(err), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/morph_pipe_ctrl.md
MORPH_PIPE_CTRL -- requirements
Module: morph_pipe_ctrl

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- PIC_WIDTH, 250, image columns.
- PIC_HEIGHT, 250, image rows.
- PIC_X_START, 310, first display column of the processed window.
- PIC_Y_START, 10, first display row.
- PRE_LINES, 2, lines prefilled before the display window.
- LEAD, 12, cycles between row trigger and window column start.
- ADDR_W, 16, ROM address width.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- lcd_pclk, in, 1, sole clock.
- rst, in, 1, asynchronous active-high reset.
- frame_start, in, 1, one-cycle frame pulse.
- pixel_xpos, in, 11, raster column.
- pixel_ypos, in, 11, raster row.
- fifo_rst_busy, in, 1, line-buffer reset in progress.
- fifo_rst, out, 1, line-buffer reset pulse.
- rom_rd_en, out, 1, ROM read strobe.
- rom_addr, out, ADDR_W, ROM address.
- lb_wr_en, out, 1, line-buffer write.
- lb_rd_en, out, 1, line-buffer pop.
- win_valid, out, 1, 3x3 window valid.
- busy, out, 1, frame in progress.
- frame_done, out, 1, one-cycle completion pulse.
- err, out, 1, sticky sequencing error.

Function
REQ-003 The FSM SHALL have states IDLE, CLEAR, PREFILL, WAIT_ROW, RUN, DONE.
REQ-004 IDLE: frame_start SHALL force fifo_rst=1 for exactly one cycle, set rom_addr=0, and move to CLEAR.
REQ-005 CLEAR: exit to PREFILL on the first cycle with fifo_rst_busy=0, no earlier than 2 cycles after fifo_rst.
REQ-006 PREFILL: rom_rd_en=1 every cycle for exactly PRE_LINES*PIC_WIDTH cycles, rom_addr +1 after each read; then go to WAIT_ROW.
REQ-007 WAIT_ROW: trigger when pixel_xpos==PIC_X_START-LEAD, pixel_ypos is in [PIC_Y_START, PIC_Y_START+PIC_HEIGHT-PRE_LINES), and pixel_ypos differs from the last triggered row; go to RUN, first read on the next cycle.
REQ-008 RUN: PIC_WIDTH consecutive reads with rom_addr incrementing, then return to WAIT_ROW; go to DONE instead once rom_addr==PIC_WIDTH*PIC_HEIGHT.
REQ-009 lb_wr_en SHALL equal rom_rd_en delayed 1 cycle (ROM latency).
REQ-010 lb_rd_en SHALL equal lb_wr_en for RUN-originated reads only; it SHALL be 0 for prefill writes.
REQ-011 win_valid SHALL equal lb_rd_en delayed 1 cycle.
REQ-012 DONE: frame_done=1 for one cycle after the last win_valid, then go to IDLE.
REQ-013 busy SHALL be 1 in every state other than IDLE.
REQ-014 rom_addr SHALL never wrap; PIC_WIDTH*PIC_HEIGHT SHALL be ≤ 2^ADDR_W. Row and read counters SHALL be sized for their maximum values.
REQ-015 frame_start in any non-IDLE state SHALL set err, abort the frame (in-flight lb_wr_en and win_valid flushed, no frame_done), and restart as in REQ-004.
REQ-016 If pixel_ypos ≥ PIC_Y_START+PIC_HEIGHT-PRE_LINES while in WAIT_ROW with rows still outstanding, the block SHALL set err and go to DONE.
REQ-017 A trigger condition arising during RUN SHALL be ignored: no overlap and no queueing.
REQ-018 err SHALL be sticky and cleared only by rst.

Reset
REQ-019 rst SHALL asynchronously force state=IDLE, rom_addr=0, all 1-bit outputs=0, and all counters and delay stages=0.
REQ-020 Release of rst SHALL take effect on the next lcd_pclk edge. Assertion of rst mid-frame SHALL discard all progress with no frame_done.

Verification
REQ-021 Nominal frame (PIC_WIDTH=8, PIC_HEIGHT=4, PRE_LINES=2, LEAD=3, PIC_X_START=20, PIC_Y_START=2):
- frame_start → 1 fifo_rst pulse, then 16 prefill reads at addresses 0-15.
- Two RUN bursts of 8, at ypos 2 and 3, addresses 16-31.
- 16 win_valid cycles in total, then one frame_done.
REQ-022 Hold fifo_rst_busy=1 for 10 cycles → no rom_rd_en until the cycle after it falls.
REQ-023 Trigger timing: xpos==17 at ypos=2 → first RUN read 1 cycle later, lb_rd_en 2 cycles later, win_valid 3 cycles later.
REQ-024 frame_start issued mid-PREFILL at rom_addr=9 → err=1, rom_addr=0, fifo_rst pulse, clean restart with no frame_done for the aborted frame.
REQ-025 Hold xpos away from 17 until ypos=4 → err=1, DONE entered, frame_done pulse, busy=0 the cycle after.
REQ-026 Assert rst during RUN → all outputs 0 immediately; the next frame_start yields a nominal frame.
